// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage feeding the IF/ID pipeline register. Keeps the
//   fetch PC, runs a single-outstanding-request handshake to program memory
//   and buffers returned instructions in a small FIFO whose head is
//   presented downstream with a valid flag.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   reset             asynchronous, active-low reset
//   any_lsu_waiting   pipeline stall: blocks pops from the buffer only
//   redirect_valid    taken branch/jump: flushes buffer, drops in-flight data
//   redirect_pc       new fetch PC
//   halt              level-sensitive: stops issuing new memory requests
//   mem_read_valid    registered memory request
//   mem_read_address  registered request address, stable while valid
//   mem_read_ready    request accepted, mem_read_data valid this cycle
//   mem_read_data     returned instruction
//   if_valid          buffer head holds a valid instruction
//   if_instruction    head instruction
//   if_pc             PC of head instruction
module fetch_stage #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 any_lsu_waiting,
  input  logic                 redirect_valid,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 if_valid,
  output logic [DATA_BITS-1:0] if_instruction,
  output logic [ADDR_BITS-1:0] if_pc
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

  // Architectural state
  logic [ADDR_BITS-1:0] pc_reg, pc_next;
  logic                 req_pending_reg, req_pending_next;
  logic [ADDR_BITS-1:0] req_addr_reg, req_addr_next;
  logic                 discard_reg, discard_next;
  logic [PTR_BITS-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_BITS-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_BITS-1:0]  count_reg, count_next;

  // Fetch buffer storage: {pc, instruction} per entry
  logic [ADDR_BITS-1:0] fifo_pc_reg    [FIFO_DEPTH];
  logic [DATA_BITS-1:0] fifo_instr_reg [FIFO_DEPTH];

  // Per-cycle events
  logic handshake;
  logic push;
  logic pop;
  logic issue;

  always_comb begin
    handshake = req_pending_reg && mem_read_ready;
    // A response landing on a redirect edge belongs to the old stream.
    push      = handshake && !discard_reg && !redirect_valid;
    pop       = (count_reg != '0) && !any_lsu_waiting && !redirect_valid;

    count_next = count_reg + CNT_BITS'(push) - CNT_BITS'(pop);
    if (redirect_valid) begin
      count_next = '0;
    end

    // Occupancy after this edge bounds issue, so the single in-flight
    // response always has a free slot when it returns.
    issue = (!req_pending_reg || handshake) && !halt && !redirect_valid &&
            (count_next < CNT_BITS'(FIFO_DEPTH));

    pc_next          = pc_reg;
    req_pending_next = req_pending_reg;
    req_addr_next    = req_addr_reg;
    discard_next     = discard_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;

    if (handshake) begin
      req_pending_next = 1'b0;
      discard_next     = 1'b0;
    end
    if (issue) begin
      req_pending_next = 1'b1;
      req_addr_next    = pc_reg;
      pc_next          = pc_reg + ADDR_BITS'(1);
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_BITS'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_BITS'(1);
    end

    // Redirect never withdraws a pending request; it only marks the
    // response for dropping if it has not completed on this edge.
    if (redirect_valid) begin
      pc_next      = redirect_pc;
      discard_next = req_pending_reg && !mem_read_ready;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg          <= '0;
      req_pending_reg <= 1'b0;
      req_addr_reg    <= '0;
      discard_reg     <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      pc_reg          <= pc_next;
      req_pending_reg <= req_pending_next;
      req_addr_reg    <= req_addr_next;
      discard_reg     <= discard_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
    end
  end

  // Storage is reset too so the head outputs are never X after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_reg[i]    <= '0;
        fifo_instr_reg[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_reg[wr_ptr_reg]    <= req_addr_reg;
      fifo_instr_reg[wr_ptr_reg] <= mem_read_data;
    end
  end

  assign mem_read_valid   = req_pending_reg;
  assign mem_read_address = req_addr_reg;
  assign if_valid         = (count_reg != '0);
  assign if_instruction   = fifo_instr_reg[rd_ptr_reg];
  assign if_pc            = fifo_pc_reg[rd_ptr_reg];

endmodule
